// File: rtl/m_array_loader.sv
// Operand loader and sequencer for the divisible-by-7 finder: streams 16 bytes into a
// register array, starts the finder, captures its result and acknowledges it.
module m_array_loader #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Go,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_Valid,
  output logic             Din_Ready,
  input  logic [3:0]       Rd_Addr,
  output logic [WIDTH-1:0] Rd_Data,
  output logic             Fnd_Start,
  output logic             Fnd_Ack,
  input  logic [WIDTH-1:0] Fnd_Max,
  input  logic             Fnd_Done_F,
  input  logic             Fnd_Done_NF,
  output logic [WIDTH-1:0] Result,
  output logic             Result_Found,
  output logic             Result_Valid,
  input  logic             Result_Ack,
  output logic [4:0]       Count,
  output logic             Qi,
  output logic             Qld,
  output logic             Qst,
  output logic             Qw,
  output logic             Qr
);

  typedef enum logic [2:0] {StIni, StLoad, StStart, StWait, StResult} state_e;

  state_e           r_state, w_state_d;
  logic [4:0]       r_count, w_count_d;
  logic [WIDTH-1:0] r_result, w_result_d;
  logic             r_found, w_found_d;
  logic             w_wr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= StIni;
      r_count  <= 5'd0;
      r_result <= '0;
      r_found  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_count  <= w_count_d;
      r_result <= w_result_d;
      r_found  <= w_found_d;
    end
  end

  // Array has no reset; stale entries after a reset are simply overwritten by the next load.
  always_ff @(posedge Clk) begin
    if (w_wr) r_mem[r_count[3:0]] <= Din;
  end

  always_comb begin
    w_state_d  = r_state;
    w_count_d  = r_count;
    w_result_d = r_result;
    w_found_d  = r_found;
    w_wr       = 1'b0;
    unique case (r_state)
      StIni: begin
        if (Go) begin
          w_state_d = StLoad;
          w_count_d = 5'd0;
        end
      end
      StLoad: begin
        if (Din_Valid) begin
          w_wr      = 1'b1;
          w_count_d = r_count + 5'd1;
          if (r_count == 5'(DEPTH - 1)) w_state_d = StStart;
        end
      end
      StStart: w_state_d = StWait;
      StWait: begin
        // Done_F wins if the finder ever raises both.
        if (Fnd_Done_F) begin
          w_result_d = Fnd_Max;
          w_found_d  = 1'b1;
          w_state_d  = StResult;
        end else if (Fnd_Done_NF) begin
          w_result_d = '0;
          w_found_d  = 1'b0;
          w_state_d  = StResult;
        end
      end
      StResult: begin
        if (Result_Ack) w_state_d = StIni;
      end
      default: w_state_d = StIni;
    endcase
  end

  assign Rd_Data      = r_mem[Rd_Addr];
  assign Din_Ready    = (r_state == StLoad);
  assign Fnd_Start    = (r_state == StStart);
  assign Fnd_Ack      = (r_state == StResult);
  assign Result_Valid = (r_state == StResult);
  assign Result       = r_result;
  assign Result_Found = r_found;
  assign Count        = r_count;
  assign Qi           = (r_state == StIni);
  assign Qld          = (r_state == StLoad);
  assign Qst          = (r_state == StStart);
  assign Qw           = (r_state == StWait);
  assign Qr           = (r_state == StResult);

endmodule

// File: tb/tb_m_array_loader.sv
// Directed bench for m_array_loader: table of load/finder scenarios plus a mid-load reset.
module tb_m_array_loader;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Go;
  logic [7:0] Din;
  logic       Din_Valid;
  logic       Din_Ready;
  logic [3:0] Rd_Addr;
  logic [7:0] Rd_Data;
  logic       Fnd_Start;
  logic       Fnd_Ack;
  logic [7:0] Fnd_Max;
  logic       Fnd_Done_F;
  logic       Fnd_Done_NF;
  logic [7:0] Result;
  logic       Result_Found;
  logic       Result_Valid;
  logic       Result_Ack;
  logic [4:0] Count;
  logic       Qi, Qld, Qst, Qw, Qr;

  m_array_loader dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Go           (Go),
    .Din          (Din),
    .Din_Valid    (Din_Valid),
    .Din_Ready    (Din_Ready),
    .Rd_Addr      (Rd_Addr),
    .Rd_Data      (Rd_Data),
    .Fnd_Start    (Fnd_Start),
    .Fnd_Ack      (Fnd_Ack),
    .Fnd_Max      (Fnd_Max),
    .Fnd_Done_F   (Fnd_Done_F),
    .Fnd_Done_NF  (Fnd_Done_NF),
    .Result       (Result),
    .Result_Found (Result_Found),
    .Result_Valid (Result_Valid),
    .Result_Ack   (Result_Ack),
    .Count        (Count),
    .Qi           (Qi),
    .Qld          (Qld),
    .Qst          (Qst),
    .Qw           (Qw),
    .Qr           (Qr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0][7:0] data;
    bit               gaps;
    bit               interfere;
    bit               both;
    logic [7:0]       exp_res;
    bit               exp_found;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] mx;
    @(negedge Clk);
    Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
    chk("load_entered", 32'(Qld), 32'd1);
    chk("load_ready", 32'(Din_Ready), 32'd1);
    chk("load_count0", 32'(Count), 32'd0);
    for (int i = 0; i < 16; i++) begin
      Din       = v.data[i];
      Din_Valid = 1'b1;
      @(negedge Clk);
      if (v.gaps && i < 15) begin
        Din_Valid = 1'b0;
        Din       = 8'hEE;
        @(negedge Clk);
        @(negedge Clk);
        chk("gap_count", 32'(Count), 32'(i + 1));
      end
    end
    Din_Valid = 1'b0;
    chk("start_count16", 32'(Count), 32'd16);
    chk("start_pulse", 32'(Fnd_Start), 32'd1);
    chk("start_state", 32'(Qst), 32'd1);
    @(negedge Clk);
    chk("start_dropped", 32'(Fnd_Start), 32'd0);
    chk("wait_state", 32'(Qw), 32'd1);
    if (v.interfere) begin
      Go        = 1'b1;
      Din_Valid = 1'b1;
      Din       = 8'hAA;
      @(negedge Clk);
      @(negedge Clk);
      chk("wait_ignore_state", 32'(Qw), 32'd1);
      chk("wait_ignore_count", 32'(Count), 32'd16);
      Go        = 1'b0;
      Din_Valid = 1'b0;
    end
    // Behavioural finder: scan the array one index per cycle.
    mx = 8'd0;
    for (int i = 0; i < 16; i++) begin
      Rd_Addr = 4'(i);
      #1;
      chk($sformatf("rd_m%0d", i), 32'(Rd_Data), 32'(v.data[i]));
      if (Rd_Data != 8'd0 && (Rd_Data % 8'd7) == 8'd0 && Rd_Data > mx) mx = Rd_Data;
      @(negedge Clk);
    end
    chk("wait_hold", 32'(Qw), 32'd1);
    chk("wait_no_valid", 32'(Result_Valid), 32'd0);
    if (v.both) begin
      Fnd_Done_F  = 1'b1;
      Fnd_Done_NF = 1'b1;
      Fnd_Max     = 8'h38;
    end else if (mx != 8'd0) begin
      Fnd_Done_F = 1'b1;
      Fnd_Max    = mx;
    end else begin
      Fnd_Done_NF = 1'b1;
      Fnd_Max     = 8'hFF;
    end
    @(negedge Clk);
    chk("res_state", 32'(Qr), 32'd1);
    chk("res_valid", 32'(Result_Valid), 32'd1);
    chk("res_ack_out", 32'(Fnd_Ack), 32'd1);
    chk("res_value", 32'(Result), 32'(v.exp_res));
    chk("res_found", 32'(Result_Found), 32'(v.exp_found));
    Fnd_Done_F  = 1'b0;
    Fnd_Done_NF = 1'b0;
    if (v.interfere) begin
      Go        = 1'b1;
      Din_Valid = 1'b1;
      Din       = 8'hAA;
      @(negedge Clk);
      chk("res_ignore_state", 32'(Qr), 32'd1);
      chk("res_ignore_count", 32'(Count), 32'd16);
      chk("res_held", 32'(Result), 32'(v.exp_res));
      Go        = 1'b0;
      Din_Valid = 1'b0;
    end
    Result_Ack = 1'b1;
    @(negedge Clk);
    Result_Ack = 1'b0;
    chk("back_ini", 32'(Qi), 32'd1);
    chk("back_no_valid", 32'(Result_Valid), 32'd0);
    chk("back_no_ack", 32'(Fnd_Ack), 32'd0);
    chk("back_res_kept", 32'(Result), 32'(v.exp_res));
    chk("back_found_kept", 32'(Result_Found), 32'(v.exp_found));
    if (v.interfere) begin
      for (int i = 0; i < 16; i++) begin
        Rd_Addr = 4'(i);
        #1;
        chk($sformatf("nowrite_m%0d", i), 32'(Rd_Data), 32'(v.data[i]));
      end
    end
  endtask

  initial begin
    logic [7:0] d0 [16] = '{8'd3, 8'd14, 8'd70, 8'd9, 8'd0, 8'd21, 8'd255, 8'd49,
                            8'd63, 8'd8, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd56};
    for (int i = 0; i < 16; i++) begin
      vecs[0].data[i] = d0[i];
      vecs[1].data[i] = 8'h05;
      vecs[2].data[i] = 8'(8'h10 + i);
      vecs[3].data[i] = 8'(i + 1);
      vecs[4].data[i] = 8'h05;
      vecs[5].data[i] = 8'(8'h30 + i);
    end
    // {gaps, interfere, both, expected result, expected found}
    vecs[0].gaps = 0; vecs[0].interfere = 0; vecs[0].both = 0;
    vecs[0].exp_res = 8'd70; vecs[0].exp_found = 1;
    vecs[1].gaps = 0; vecs[1].interfere = 0; vecs[1].both = 0;
    vecs[1].exp_res = 8'd0;  vecs[1].exp_found = 0;
    vecs[2].gaps = 1; vecs[2].interfere = 0; vecs[2].both = 0;
    vecs[2].exp_res = 8'd28; vecs[2].exp_found = 1;
    vecs[3].gaps = 0; vecs[3].interfere = 1; vecs[3].both = 0;
    vecs[3].exp_res = 8'd14; vecs[3].exp_found = 1;
    vecs[4].gaps = 0; vecs[4].interfere = 0; vecs[4].both = 1;
    vecs[4].exp_res = 8'h38; vecs[4].exp_found = 1;
    vecs[5].gaps = 0; vecs[5].interfere = 0; vecs[5].both = 0;
    vecs[5].exp_res = 8'd63; vecs[5].exp_found = 1;

    Reset_n = 1'b0; Go = 1'b0; Din = 8'h00; Din_Valid = 1'b0; Rd_Addr = 4'd0;
    Fnd_Max = 8'h00; Fnd_Done_F = 1'b0; Fnd_Done_NF = 1'b0; Result_Ack = 1'b0;
    #12;
    chk("rst_qi", 32'(Qi), 32'd1);
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_result", 32'(Result), 32'd0);
    chk("rst_found", 32'(Result_Found), 32'd0);
    chk("rst_outs", 32'({Din_Ready, Fnd_Start, Fnd_Ack, Result_Valid}), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Din_Valid alone must not leave INI.
    Din_Valid = 1'b1;
    @(negedge Clk);
    Din_Valid = 1'b0;
    chk("ini_ignore_valid", 32'(Qi), 32'd1);
    chk("ini_ignore_count", 32'(Count), 32'd0);

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Reset after five accepted bytes, then a clean reload from M[0].
    @(negedge Clk);
    Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Din       = 8'(8'hA0 + i);
      Din_Valid = 1'b1;
      @(negedge Clk);
    end
    chk("pre_rst_count", 32'(Count), 32'd5);
    Reset_n = 1'b0;
    #1;
    chk("midrst_qi", 32'(Qi), 32'd1);
    chk("midrst_count", 32'(Count), 32'd0);
    chk("midrst_ready", 32'(Din_Ready), 32'd0);
    Din_Valid = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    run_vec(vecs[5]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
